// File: rtl/ifetch_pkg.sv
// Shared state encoding and bus constants for the instruction-fetch controller.
package ifetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_MEM   = 3'd2,
    S_LATCH = 3'd3,
    S_XFER  = 3'd4,
    S_WAIT  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  localparam logic RW_READ = 1'b1;

endpackage

// File: rtl/ifetch_fsm_pc_reg.sv
// Program counter: async reset to RESET_PC, branch load wins over increment.
module pc_reg #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d, pc_q;

  // Next PC: load has priority; increment wraps naturally at 2^ADDR_W.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + 1'b1;
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/ifetch_fsm.sv
// Instruction-fetch controller: sequences MAR/MDR/IR strobes for one or more
// memory words per instruction, with MFC timeout, fault/retry and branch load.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset; starts the first fetch on the next edge
// S_ADDR  | PC onto bus, latch into MAR; clears the MFC wait counter
// S_MEM   | memory read in progress, waiting for MFC (bounded)
// S_LATCH | memory data into MDR
// S_XFER  | MDR onto bus into IR slot word_idx; PC advances on exit
// S_WAIT  | full instruction held in IR; waits for execute done
// S_FAULT | MFC never arrived; held until retry or reset
module ifetch_fsm
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int WORDS_PER_INSTR = 1,
  parameter int MFC_TIMEOUT = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic              MFC,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              retry,
  output logic [ADDR_W-1:0] pc_out,
  output logic              PCoutEN,
  output logic              marIn,
  output logic              memEN,
  output logic              RW,
  output logic              mdReadEN,
  output logic              mdrOut,
  output logic              IRin,
  output logic [1:0]        word_idx,
  output logic              instr_valid,
  output logic              fault
);

  // Counter must hold MFC_TIMEOUT itself, since it keeps counting on the
  // cycle that expires into S_FAULT.
  localparam int CNT_W = (MFC_TIMEOUT < 2) ? 1 : $clog2(MFC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MFC_TIMEOUT - 1);
  localparam logic [1:0] WORD_LAST = 2'(WORDS_PER_INSTR - 1);

  state_t state_d, state_q;
  logic [1:0] word_d, word_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic pc_inc, pc_ld;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .inc      (pc_inc),
    .load     (pc_ld),
    .load_val (pc_load_val),
    .pc       (pc_out)
  );

  // State, word slot and MFC wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic plus PC increment/load requests.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_ADDR;
      end
      S_ADDR: begin
        state_d = S_MEM;
        cnt_d   = '0;
      end
      S_MEM: begin
        // MFC wins even on the cycle the wait would expire.
        if (MFC) begin
          state_d = S_LATCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_FAULT;
          end
        end
      end
      S_LATCH: begin
        state_d = S_XFER;
      end
      S_XFER: begin
        pc_inc = 1'b1;
        if (word_q == WORD_LAST) begin
          state_d = S_WAIT;
          word_d  = '0;
        end else begin
          state_d = S_ADDR;
          word_d  = word_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (done) begin
          state_d = S_ADDR;
          pc_ld   = pc_load;
        end
      end
      S_FAULT: begin
        // PC and word slot untouched so the same word is refetched.
        if (retry) begin
          state_d = S_ADDR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode from the state register only.
  always_comb begin
    PCoutEN     = 1'b0;
    marIn       = 1'b0;
    memEN       = 1'b0;
    RW          = 1'b0;
    mdReadEN    = 1'b0;
    mdrOut      = 1'b0;
    IRin        = 1'b0;
    instr_valid = 1'b0;
    fault       = 1'b0;
    case (state_q)
      S_ADDR: begin
        PCoutEN = 1'b1;
        marIn   = 1'b1;
      end
      S_MEM: begin
        memEN = 1'b1;
        RW    = RW_READ;
      end
      S_LATCH: begin
        memEN    = 1'b1;
        RW       = RW_READ;
        mdReadEN = 1'b1;
      end
      S_XFER: begin
        mdrOut = 1'b1;
        IRin   = 1'b1;
      end
      S_WAIT: begin
        instr_valid = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign word_idx = word_q;

endmodule

// File: tb/tb_ifetch_fsm.sv
// Directed bench for ifetch_fsm: one-word instance (RESET_PC=0) and a
// three-word instance (RESET_PC=0xFFFF) sharing clock, reset and inputs.
module tb_ifetch_fsm;

  // Output vector order: PCoutEN marIn memEN RW mdReadEN mdrOut IRin instr_valid fault
  localparam logic [8:0] O_IDLE  = 9'b000000000;
  localparam logic [8:0] O_ADDR  = 9'b110000000;
  localparam logic [8:0] O_MEM   = 9'b001100000;
  localparam logic [8:0] O_LATCH = 9'b001110000;
  localparam logic [8:0] O_XFER  = 9'b000001100;
  localparam logic [8:0] O_WAIT  = 9'b000000010;
  localparam logic [8:0] O_FAULT = 9'b000000001;

  logic clk = 1'b0;
  logic rst;
  logic done, MFC, pc_load, retry;
  logic [15:0] pc_load_val;

  logic [15:0] pc1, pc3;
  logic [1:0]  wi1, wi3;
  logic pcoe1, mar1, mem1, rw1, mdr1, mdo1, ir1, iv1, flt1;
  logic pcoe3, mar3, mem3, rw3, mdr3, mdo3, ir3, iv3, flt3;
  logic [8:0] o1, o3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign o1 = {pcoe1, mar1, mem1, rw1, mdr1, mdo1, ir1, iv1, flt1};
  assign o3 = {pcoe3, mar3, mem3, rw3, mdr3, mdo3, ir3, iv3, flt3};

  ifetch_fsm #(.ADDR_W(16), .WORDS_PER_INSTR(1), .MFC_TIMEOUT(15), .RESET_PC(16'h0000)) u_dut1 (
    .clk(clk), .rst(rst), .done(done), .MFC(MFC), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .retry(retry), .pc_out(pc1),
    .PCoutEN(pcoe1), .marIn(mar1), .memEN(mem1), .RW(rw1), .mdReadEN(mdr1),
    .mdrOut(mdo1), .IRin(ir1), .word_idx(wi1), .instr_valid(iv1), .fault(flt1)
  );

  ifetch_fsm #(.ADDR_W(16), .WORDS_PER_INSTR(3), .MFC_TIMEOUT(15), .RESET_PC(16'hFFFF)) u_dut3 (
    .clk(clk), .rst(rst), .done(done), .MFC(MFC), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .retry(retry), .pc_out(pc3),
    .PCoutEN(pcoe3), .marIn(mar3), .memEN(mem3), .RW(rw3), .mdReadEN(mdr3),
    .mdrOut(mdo3), .IRin(ir3), .word_idx(wi3), .instr_valid(iv3), .fault(flt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; done = 1'b0; MFC = 1'b0; pc_load = 1'b0; retry = 1'b0;
    pc_load_val = 16'h0000;
    #2;
    chk("reset_outs1", {23'd0, o1}, {23'd0, O_IDLE});
    chk("reset_pc1", {16'd0, pc1}, 32'h0000);
    chk("reset_word1", {30'd0, wi1}, 32'd0);
    chk("reset_pc3", {16'd0, pc3}, 32'hFFFF);

    // Basic one-word fetch, MFC on third S_MEM cycle.
    nxt(); rst = 1'b0;
    nxt(); chk("b_addr", {23'd0, o1}, {23'd0, O_ADDR}); chk("b_addr_pc", {16'd0, pc1}, 32'h0000);
    nxt(); chk("b_mem1", {23'd0, o1}, {23'd0, O_MEM});
    nxt(); chk("b_mem2", {23'd0, o1}, {23'd0, O_MEM});
    nxt(); chk("b_mem3", {23'd0, o1}, {23'd0, O_MEM}); MFC = 1'b1;
    nxt(); chk("b_latch", {23'd0, o1}, {23'd0, O_LATCH}); MFC = 1'b0;
    nxt(); chk("b_xfer", {23'd0, o1}, {23'd0, O_XFER}); chk("b_xfer_pc", {16'd0, pc1}, 32'h0000);
    chk("b_xfer_idx", {30'd0, wi1}, 32'd0);
    nxt(); chk("b_wait1", {23'd0, o1}, {23'd0, O_WAIT}); chk("b_wait_pc", {16'd0, pc1}, 32'h0001);
    nxt(); chk("b_wait2", {23'd0, o1}, {23'd0, O_WAIT}); done = 1'b1;
    nxt(); chk("b_refetch", {23'd0, o1}, {23'd0, O_ADDR}); chk("b_refetch_pc", {16'd0, pc1}, 32'h0001);
    done = 1'b0; MFC = 1'b1;

    // Second fetch; done/pc_load outside S_WAIT must be ignored.
    nxt(); chk("f2_mem", {23'd0, o1}, {23'd0, O_MEM});
    nxt(); chk("f2_latch", {23'd0, o1}, {23'd0, O_LATCH});
    MFC = 1'b0; done = 1'b1; pc_load = 1'b1; pc_load_val = 16'h5555;
    nxt(); chk("f2_xfer", {23'd0, o1}, {23'd0, O_XFER}); chk("f2_ignore_pc", {16'd0, pc1}, 32'h0001);
    done = 1'b0; pc_load = 1'b0;
    nxt(); chk("f2_wait", {23'd0, o1}, {23'd0, O_WAIT}); chk("f2_wait_pc", {16'd0, pc1}, 32'h0002);

    // Branch load.
    done = 1'b1; pc_load = 1'b1; pc_load_val = 16'h1234;
    nxt(); chk("br_addr", {23'd0, o1}, {23'd0, O_ADDR}); chk("br_pc", {16'd0, pc1}, 32'h1234);
    done = 1'b0; pc_load = 1'b0; pc_load_val = 16'h0000;

    // Timeout: 15 S_MEM cycles then S_FAULT.
    for (int i = 1; i <= 15; i++) begin
      nxt(); chk($sformatf("to_mem%0d", i), {23'd0, o1}, {23'd0, O_MEM});
    end
    nxt(); chk("to_fault", {23'd0, o1}, {23'd0, O_FAULT});
    chk("to_fault_pc", {16'd0, pc1}, 32'h1234); chk("to_fault_idx", {30'd0, wi1}, 32'd0);
    done = 1'b1; MFC = 1'b1;
    nxt(); chk("to_fault_hold", {23'd0, o1}, {23'd0, O_FAULT});
    done = 1'b0; MFC = 1'b0; retry = 1'b1;
    nxt(); chk("to_retry_addr", {23'd0, o1}, {23'd0, O_ADDR}); chk("to_retry_pc", {16'd0, pc1}, 32'h1234);
    retry = 1'b0;

    // MFC on the 15th cycle beats the timeout.
    for (int i = 1; i <= 14; i++) begin
      nxt();
    end
    nxt(); chk("edge_mem15", {23'd0, o1}, {23'd0, O_MEM}); MFC = 1'b1;
    nxt(); chk("edge_latch", {23'd0, o1}, {23'd0, O_LATCH}); MFC = 1'b0;
    nxt(); chk("edge_xfer", {23'd0, o1}, {23'd0, O_XFER});
    nxt(); chk("edge_wait_pc", {16'd0, pc1}, 32'h1235); done = 1'b1;
    nxt(); done = 1'b0;
    nxt(); chk("rst_pre_mem", {23'd0, o1}, {23'd0, O_MEM});

    // Asynchronous reset mid-S_MEM, observed before the next clock edge.
    #2 rst = 1'b1;
    #1;
    chk("arst_outs", {23'd0, o1}, {23'd0, O_IDLE});
    chk("arst_pc", {16'd0, pc1}, 32'h0000);
    chk("arst_rw", {31'd0, rw1}, 32'd0);
    nxt(); rst = 1'b0; MFC = 1'b1;

    // Three-word instance from 0xFFFF with immediate MFC; PC wraps.
    nxt(); chk("m_addr0", {23'd0, o3}, {23'd0, O_ADDR}); chk("m_pc0", {16'd0, pc3}, 32'hFFFF);
    nxt(); chk("m_mem0", {23'd0, o3}, {23'd0, O_MEM});
    nxt(); chk("m_latch0", {23'd0, o3}, {23'd0, O_LATCH});
    nxt(); chk("m_xfer0", {23'd0, o3}, {23'd0, O_XFER}); chk("m_idx0", {30'd0, wi3}, 32'd0);
    nxt(); chk("m_addr1", {23'd0, o3}, {23'd0, O_ADDR}); chk("m_wrap_pc", {16'd0, pc3}, 32'h0000);
    nxt(); nxt();
    nxt(); chk("m_xfer1", {23'd0, o3}, {23'd0, O_XFER}); chk("m_idx1", {30'd0, wi3}, 32'd1);
    nxt(); chk("m_addr2_pc", {16'd0, pc3}, 32'h0001);
    nxt(); nxt();
    nxt(); chk("m_xfer2", {23'd0, o3}, {23'd0, O_XFER}); chk("m_idx2", {30'd0, wi3}, 32'd2);
    nxt(); chk("m_wait", {23'd0, o3}, {23'd0, O_WAIT}); chk("m_end_pc", {16'd0, pc3}, 32'h0002);
    chk("m_end_idx", {30'd0, wi3}, 32'd0);
    MFC = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
